// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  // Width needed to count 0..max_burst inclusive
  function automatic int unsigned burst_w(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_prio.sv
// Owner FSM and burst counter: picks at most one requester per cycle and
// bounds consecutive grants to one side while the other side is waiting.
module dmem_arb_prio
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic c_req,
  input  logic d_req,
  output logic grant_core,
  output logic grant_dma
);

  localparam int unsigned BW = burst_w(MAX_BURST);

  owner_t          owner_q, owner_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic            burst_full;
  logic            contend;

  assign burst_full = (burst_q >= BW'(MAX_BURST));
  assign contend    = c_req & d_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_IDLE;
      burst_q <= '0;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
    end
  end

  // Next owner and burst length, decided in the same cycle as the grant
  always_comb begin
    owner_d = OWN_IDLE;
    burst_d = '0;
    if (contend) begin
      case (owner_q)
        OWN_CORE: owner_d = burst_full ? OWN_DMA  : OWN_CORE;
        OWN_DMA:  owner_d = burst_full ? OWN_CORE : OWN_DMA;
        default:  owner_d = OWN_CORE;
      endcase
    end else if (c_req) begin
      owner_d = OWN_CORE;
    end else if (d_req) begin
      owner_d = OWN_DMA;
    end
    if (owner_d != OWN_IDLE) begin
      if (contend && (owner_d == owner_q)) begin
        burst_d = burst_full ? burst_q : burst_q + BW'(1);
      end else begin
        burst_d = BW'(1);
      end
    end
  end

  // Grants are suppressed while reset is asserted
  always_comb begin
    grant_core = 1'b0;
    grant_dma  = 1'b0;
    if (rst_n) begin
      grant_core = (owner_d == OWN_CORE);
      grant_dma  = (owner_d == OWN_DMA);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between core and DMA ports.
// Optional range check enabled by defining DMEM_ARB_RANGE_CHECK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 64,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_gnt,
  output logic                  c_rvalid,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  err
);

`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  logic                  grant_core, grant_dma, any_gnt;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  oor_c;

  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  c_rvalid_q, c_rvalid_d;
  logic                  d_rvalid_q, d_rvalid_d;
  logic                  err_q, err_d;

  dmem_arb_prio #(
    .MAX_BURST (MAX_BURST)
  ) u_prio (
    .clk        (clk),
    .rst_n      (rst_n),
    .c_req      (c_req),
    .d_req      (d_req),
    .grant_core (grant_core),
    .grant_dma  (grant_dma)
  );

  assign c_gnt   = grant_core;
  assign d_gnt   = grant_dma;
  assign any_gnt = grant_core | grant_dma;

  // Route the granted side onto the memory bus; idle bus is all zero
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (grant_core) begin
      sel_we    = c_we;
      sel_addr  = c_addr;
      sel_wdata = c_wdata;
    end else if (grant_dma) begin
      sel_we    = d_we;
      sel_addr  = d_addr;
      sel_wdata = d_wdata;
    end
  end

  assign oor_c = RANGE_CHECK &&
                 ({2'b00, sel_addr[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(MEM_SIZE));

  assign mem_wr_en   = any_gnt & sel_we & ~oor_c;
  assign mem_addr    = sel_addr;
  assign mem_wr_data = sel_wdata;

  // Read capture and one-cycle response pulses
  always_comb begin
    rdata_d    = rdata_q;
    c_rvalid_d = grant_core & ~c_we;
    d_rvalid_d = grant_dma & ~d_we;
    err_d      = any_gnt & oor_c;
    if (any_gnt && !sel_we) begin
      rdata_d = oor_c ? '0 : mem_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q    <= '0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      c_rvalid_q <= c_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      err_q      <= err_d;
    end
  end

  assign rdata    = rdata_q;
  assign c_rvalid = c_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural single-port memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid, mem_wr_en, err;
  logic [31:0] rdata, mem_addr, mem_wr_data, mem_rd_data;

  logic [31:0] mem [64];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        c_rv;
    logic        d_rv;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  dmem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .c_req       (c_req),
    .c_we        (c_we),
    .c_addr      (c_addr),
    .c_wdata     (c_wdata),
    .c_gnt       (c_gnt),
    .c_rvalid    (c_rvalid),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_gnt       (d_gnt),
    .d_rvalid    (d_rvalid),
    .rdata       (rdata),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Memory: word index wraps modulo 64
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr[7:2]] <= mem_wr_data;
  end
  assign mem_rd_data = mem[mem_addr[7:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: each response cycle pops one expected entry
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (c_rvalid || d_rvalid || err || sb_q.size() != 0)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp c_rvalid=%0b d_rvalid=%0b err=%0b", c_rvalid, d_rvalid, err);
      end else begin
        e = sb_q.pop_front();
        if (c_rvalid !== e.c_rv || d_rvalid !== e.d_rv || err !== e.err ||
            ((e.c_rv || e.d_rv) && rdata !== e.rdata)) begin
          errors++;
          $display("FAIL resp actual c_rv=%0b d_rv=%0b err=%0b rdata=%h required c_rv=%0b d_rv=%0b err=%0b rdata=%h",
                   c_rvalid, d_rvalid, err, rdata, e.c_rv, e.d_rv, e.err, e.rdata);
        end
      end
    end
  end

  // One cycle of stimulus starting at a negedge; checks grant and memory bus
  task automatic cyc(input string nm,
                     input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                     input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                     input logic ecg, input logic edg, input logic [31:0] erd);
    exp_t        e;
    logic [31:0] ga, gd;
    logic        gw, oor;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    #1;
    ga  = ecg ? ca : (edg ? da : 32'h0);
    gd  = ecg ? cd : (edg ? dd : 32'h0);
    gw  = (ecg & cw) | (edg & dw);
    oor = 1'b0;
`ifdef DMEM_ARB_RANGE_CHECK_EN
    oor = (ecg | edg) && (ga[31:2] >= 30'd64);
`endif
    chk({nm, ".c_gnt"}, 32'(c_gnt), 32'(ecg));
    chk({nm, ".d_gnt"}, 32'(d_gnt), 32'(edg));
    chk({nm, ".mem_wr_en"}, 32'(mem_wr_en), 32'(gw & ~oor));
    chk({nm, ".mem_addr"}, mem_addr, ga);
    chk({nm, ".mem_wr_data"}, mem_wr_data, gd);
    if ((ecg | edg) && (!gw || oor)) begin
      e.c_rv  = ecg & ~cw;
      e.d_rv  = edg & ~dw;
      e.rdata = oor ? 32'h0 : erd;
      e.err   = oor;
      sb_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input string nm);
    cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  localparam logic [31:0] BEEF = 32'hDEADBEEF;
  localparam logic [31:0] ONES = 32'h11111111;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset.c_gnt", 32'(c_gnt), 32'h0);
    chk("reset.rdata", rdata, 32'h0);
    chk("reset.resp", {29'h0, c_rvalid, d_rvalid, err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle("idle0");

    // Core write then read of 0x10; DMA preloads word 1
    cyc("c_wr", 1, 1, 32'h10, BEEF, 0, 0, 0, 0, 1, 0, 0);
    cyc("c_rd", 1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0, BEEF);
    cyc("d_wr", 0, 0, 0, 0, 1, 1, 32'h4, ONES, 0, 1, 0);
    idle("idle1");

    // Simultaneous rise from idle, then DMA alone with no gap
    cyc("both_rise", 1, 0, 32'h10, 0, 1, 0, 32'h4, 0, 1, 0, BEEF);
    cyc("d_alone", 0, 0, 0, 0, 1, 0, 32'h4, 0, 0, 1, ONES);
    idle("idle2");

    // Continuous contention alternates in bursts of four
    for (int i = 0; i < 10; i++) begin
      logic ec;
      ec = ((i / 4) % 2) == 0;
      cyc($sformatf("burst%0d", i), 1, 0, 32'h10, 0, 1, 0, 32'h4, 0, ec, ~ec, ec ? BEEF : ONES);
    end
    idle("idle3");

    // A single idle cycle mid-burst restarts the count with core
    cyc("pre0", 1, 0, 32'h10, 0, 1, 0, 32'h4, 0, 1, 0, BEEF);
    cyc("pre1", 1, 0, 32'h10, 0, 1, 0, 32'h4, 0, 1, 0, BEEF);
    idle("gap");
    for (int i = 0; i < 5; i++) begin
      logic ec;
      ec = (i < 4);
      cyc($sformatf("restart%0d", i), 1, 0, 32'h10, 0, 1, 0, 32'h4, 0, ec, ~ec, ec ? BEEF : ONES);
    end
    idle("idle4");

    // DMA access to word 65 (wraps to word 1 without range check)
    cyc("d_oor_rd", 0, 0, 0, 0, 1, 0, 32'h104, 0, 0, 1, ONES);
`ifdef DMEM_ARB_RANGE_CHECK_EN
    cyc("d_oor_wr", 0, 0, 0, 0, 1, 1, 32'h104, 32'h99, 0, 1, 0);
    cyc("d_rd_w1", 0, 0, 0, 0, 1, 0, 32'h4, 0, 0, 1, ONES);
`endif
    idle("idle5");

    // Reset asserted mid-write blocks the write immediately
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'hBAD0BAD0;
    #1;
    chk("prerst.c_gnt", 32'(c_gnt), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst.c_gnt", 32'(c_gnt), 32'h0);
    chk("rst.d_gnt", 32'(d_gnt), 32'h0);
    chk("rst.mem_wr_en", 32'(mem_wr_en), 32'h0);
    chk("rst.rdata", rdata, 32'h0);
    chk("rst.resp", {29'h0, c_rvalid, d_rvalid, err}, 32'h0);
    @(posedge clk);
    #1;
    chk("rst.word4", mem[4], BEEF);
    chk("rst.mem_wr_en2", 32'(mem_wr_en), 32'h0);
    @(negedge clk);
    c_req = 1'b0; c_we = 1'b0;
    rst_n = 1'b1;
    idle("idle6");
    cyc("post_rst_rd", 1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0, BEEF);
    idle("idle7");
    idle("idle8");

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
